fir_decim_requant: RTL and testbench

- Downstream stage of FIR_filter. Consumes the full-precision signed FIR output and keeps every DECIM-th sample.
- Requantises each kept sample by arithmetic right shift with round-half-up, then saturates it to OUT_W bits.
- Buffers results in a first-word-fall-through FIFO behind a valid/ready handshake, so a stalling sink loses data only on overflow, and that loss is flagged.

---
 rtl/fir_pkg.sv | 18 +
 rtl/sync_fifo_fwft.sv | 49 ++++
 rtl/fir_decim_requant.sv | 99 +++++++++
 tb/tb_fir_decim_requant.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter chain: default widths and the
// saturation bound helpers used when requantising wide samples.
package fir_pkg;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 16;

    // Largest value representable in a w-bit two's complement word.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head is visible on rd_data whenever valid=1.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             empty, do_rd, do_wr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;
    assign valid = ~empty;
    // A write into a full FIFO is allowed only when the head leaves the same cycle.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);
    // Empty FIFO presents zero rather than stale storage.
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr && !rst) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fir_decim_requant.sv
// Decimates the FIR output, requantises kept samples with round-half-up
// shift and saturation, and buffers them behind a valid/ready FIFO.
module fir_decim_requant
    import fir_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SHIFT      = 8,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            din_valid,
    input  logic [IN_W-1:0]                 din,
    input  logic                            clr_ovf,
    output logic [OUT_W-1:0]                dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [15:0]                     sat_count
);
    localparam int     PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam longint SMAX_L = sat_max(OUT_W);
    localparam longint SMIN_L = sat_min(OUT_W);
    localparam logic signed [IN_W:0] SMAX = (IN_W+1)'(SMAX_L);
    localparam logic signed [IN_W:0] SMIN = (IN_W+1)'(SMIN_L);
    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) <<< (SHIFT - 1);

    logic [PW-1:0]          phase;
    logic                   keep;
    logic signed [IN_W:0]   ext, rsum, s1_r;
    logic                   s1_vld;
    logic                   hi, lo, sat_hit, full, drop;
    logic [OUT_W-1:0]       q;

    assign keep = din_valid && (phase == '0);

    // Rounding add is done one bit wider so +full-scale cannot wrap negative.
    always_comb begin
        ext  = {din[IN_W-1], din};
        rsum = ext + RND;
    end

    // Decimation phase advances only on valid input samples.
    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else if (din_valid)
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
    end

    // Stage 1: register the rounded, shifted kept sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_r   <= '0;
        end else begin
            s1_vld <= keep;
            if (keep) s1_r <= rsum >>> SHIFT;
        end
    end

    // Stage 2: clamp to the output range; the result goes straight to the FIFO.
    always_comb begin
        hi      = (s1_r > SMAX);
        lo      = (s1_r < SMIN);
        q       = hi ? SMAX[OUT_W-1:0] : (lo ? SMIN[OUT_W-1:0] : s1_r[OUT_W-1:0]);
        sat_hit = s1_vld & (hi | lo);
        // Full implies dout_valid, so the only rescue is a read this cycle.
        drop    = s1_vld & full & ~dout_ready;
    end

    // Saturation counter (holds at max) and sticky overflow flag; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (sat_hit && sat_count != 16'hFFFF) sat_count <= sat_count + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    sync_fifo_fwft #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s1_vld),
        .wr_data (q),
        .rd_en   (dout_ready),
        .rd_data (dout),
        .valid   (dout_valid),
        .full    (full),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench: instance a (DECIM=1, depth 4) covers rounding, saturation,
// overflow, full+read and mid-run reset; instance b (DECIM=4, depth 16)
// covers decimation and phase restart after reset.
module tb_fir_decim_requant;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_vld = 1'b0, a_clr = 1'b0, a_rdy = 1'b0;
    logic [31:0] a_din = '0;
    logic [15:0] a_dout;
    logic        a_dv, a_ovf;
    logic [2:0]  a_lvl;
    logic [15:0] a_sat;

    logic        b_rst = 1'b1, b_vld = 1'b0, b_clr = 1'b0, b_rdy = 1'b0;
    logic [31:0] b_din = '0;
    logic [15:0] b_dout;
    logic        b_dv, b_ovf;
    logic [4:0]  b_lvl;
    logic [15:0] b_sat;

    int n_chk = 0;
    int n_err = 0;

    fir_decim_requant #(.IN_W(32), .OUT_W(16), .SHIFT(8), .DECIM(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(a_rst), .din_valid(a_vld), .din(a_din), .clr_ovf(a_clr),
        .dout(a_dout), .dout_valid(a_dv), .dout_ready(a_rdy),
        .fifo_level(a_lvl), .overflow(a_ovf), .sat_count(a_sat)
    );

    fir_decim_requant #(.IN_W(32), .OUT_W(16), .SHIFT(8), .DECIM(4), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst(b_rst), .din_valid(b_vld), .din(b_din), .clr_ovf(b_clr),
        .dout(b_dout), .dout_valid(b_dv), .dout_ready(b_rdy),
        .fifo_level(b_lvl), .overflow(b_ovf), .sat_count(b_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single sample through instance a with sink ready: visible two edges after drive.
    task automatic a_one(input string tag, input logic [31:0] d, input logic [15:0] exp);
        a_vld = 1'b1; a_din = d;
        tick();
        a_vld = 1'b0; a_din = 32'hDEADBEEF;
        tick();
        chk({tag, "_dv"}, a_dv, 1);
        chk(tag, a_dout, exp);
        tick();
        chk({tag, "_drained"}, a_dv, 0);
    endtask

    // Eight samples k*256 into instance b, optionally with idle gaps carrying junk.
    task automatic b_feed(input bit gaps);
        for (int k = 0; k < 8; k++) begin
            b_vld = 1'b1; b_din = k * 256;
            tick();
            if (gaps) begin
                b_vld = 1'b0; b_din = 32'h7FFF0000;
                tick();
            end
        end
        b_vld = 1'b0;
        tick();
    endtask

    task automatic b_drain(input string tag);
        chk({tag, "_lvl"}, b_lvl, 2);
        chk({tag, "_d0"}, b_dout, 16'h0000);
        b_rdy = 1'b1;
        tick();
        chk({tag, "_d1"}, b_dout, 16'h0004);
        chk({tag, "_dv1"}, b_dv, 1);
        tick();
        chk({tag, "_empty"}, b_dv, 0);
        b_rdy = 1'b0;
    endtask

    initial begin
        tick();
        a_rst = 1'b0; b_rst = 1'b0;
        chk("rst_dv", a_dv, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_lvl", a_lvl, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_sat", a_sat, 0);

        // Rounding and saturation
        a_rdy = 1'b1;
        a_one("rnd_pos", 32'h00001280, 16'h0013);
        a_one("rnd_neg", 32'hFFFFFE80, 16'hFFFF);
        chk("rnd_sat0", a_sat, 0);
        a_one("sat_pos", 32'h7FFFFFFF, 16'h7FFF);
        a_one("sat_neg", 32'h80000000, 16'h8000);
        chk("sat_cnt2", a_sat, 2);

        // Overflow: six samples into a depth-4 FIFO with a stalled sink
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        a_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            a_vld = 1'b1; a_din = i * 256;
            tick();
        end
        a_vld = 1'b0;
        tick();
        chk("ovf_lvl", a_lvl, 4);
        chk("ovf_flag", a_ovf, 1);
        a_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_d%0d", i), a_dout, i);
            tick();
        end
        chk("ovf_empty", a_dv, 0);
        chk("ovf_sticky", a_ovf, 1);
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        chk("ovf_clr", a_ovf, 0);

        // Full FIFO with a write and read on the same edge
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        a_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            a_vld = 1'b1; a_din = i * 256;
            tick();
        end
        a_vld = 1'b0;
        chk("fr_full", a_lvl, 4);
        a_rdy = 1'b1;
        tick();
        chk("fr_lvl", a_lvl, 4);
        chk("fr_ovf", a_ovf, 0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("fr_d%0d", i), a_dout, i);
            tick();
        end
        chk("fr_empty", a_dv, 0);

        // Reset with three entries buffered and one in stage 1
        a_rdy = 1'b0;
        a_vld = 1'b1; a_din = 32'h7FFFFFFF; tick();
        a_din = 32'h200; tick();
        a_din = 32'h300; tick();
        a_din = 32'h400; tick();
        a_vld = 1'b0;
        chk("mr_lvl3", a_lvl, 3);
        chk("mr_sat1", a_sat, 1);
        a_rst = 1'b1; tick(); a_rst = 1'b0;
        chk("mr_dv", a_dv, 0);
        chk("mr_lvl", a_lvl, 0);
        chk("mr_sat", a_sat, 0);
        tick();
        chk("mr_nopartial", a_lvl, 0);

        // Decimation by 4, continuous and with idle gaps
        b_feed(1'b0);
        b_drain("dec");
        b_feed(1'b1);
        b_drain("decgap");

        // Reset mid-phase: the next valid sample is kept
        b_vld = 1'b1; b_din = 32'h100; tick();
        b_din = 32'h200; tick();
        b_vld = 1'b0;
        b_rst = 1'b1; tick(); b_rst = 1'b0;
        chk("ph_rst_lvl", b_lvl, 0);
        b_vld = 1'b1; b_din = 32'h500; tick();
        b_vld = 1'b0; tick();
        chk("ph_dv", b_dv, 1);
        chk("ph_dout", b_dout, 16'h0005);
        chk("ph_lvl", b_lvl, 1);
        chk("b_ovf", b_ovf, 0);
        chk("b_sat", b_sat, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
